// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage.
// Holds the ALU opcode values, the EX FSM state type, the operand forward-select
// encoding and the EX/MEM load-source selector used by ex_stage_pipe.
package ex_pkg;

    // ALU opcodes as seen on in_ALUOp (zero-extended before comparison).
    localparam int unsigned OpAnd  = 0;
    localparam int unsigned OpOr   = 1;
    localparam int unsigned OpAdd  = 2;
    localparam int unsigned OpSub  = 3;
    localparam int unsigned OpSlt  = 4;
    localparam int unsigned OpSltu = 5;
    localparam int unsigned OpSll  = 6;
    localparam int unsigned OpSrl  = 7;
    localparam int unsigned OpSra  = 8;
    localparam int unsigned OpNor  = 9;
    localparam int unsigned OpXor  = 10;
    localparam int unsigned OpMul  = 12;

    typedef enum logic {
        StIdle,
        StMul
    } ex_state_e;

    // Where an ALU source operand comes from.
    typedef enum logic [1:0] {
        FwdRf,
        FwdExMem,
        FwdMemWb
    } fwd_sel_e;

    // What the EX/MEM register loads on the next edge.
    typedef enum logic [1:0] {
        ExHold,
        ExBubble,
        ExAlu,
        ExMul
    } ex_src_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         latch a/b and begin (ignored while hold is high)
//   hold          freeze all state
//   abort         drop any multiply in progress (wins over hold)
//   a, b          multiplicand / multiplier
//   busy          a multiply is in progress
//   done          the current edge completes the multiply
//   product       low DATA_W bits of a*b, valid while done is high
module ex_mul_iter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int unsigned CntW = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
    logic [DATA_W-1:0] acc_step;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;

    // Accumulator value after consuming the current multiplier bit; on the
    // last step this is already the full product, so it is exported directly.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CntW'(1));
    assign product  = acc_step;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (!hold) begin
            if (start) begin
                acc_q    <= '0;
                mcand_q  <= a;
                mplier_q <= b;
                cnt_q    <= CntW'(DATA_W);
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiply with
// stall handshake, and the EX/MEM pipeline register.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_*                       ID/EX slot: valid, control bits, opcode, registers,
//                              operands, immediate, PC+4
//   wb_valid/RegWrite/dest/data MEM/WB forwarding source
//   flush                      discard EX contents (beats mem_stall)
//   mem_stall                  downstream cannot accept; freezes the stage
//   stall_out                  combinational; upstream must hold ID/EX
//   *_out                      EX/MEM register contents
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_RegDst,
    input  logic              in_RegWrite,
    input  logic              in_ALUSrc,
    input  logic              in_MemWrite,
    input  logic              in_MemRead,
    input  logic              in_MemToReg,
    input  logic [OP_W-1:0]   in_ALUOp,
    input  logic [1:0]        in_load_mode,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] in_read_data1,
    input  logic [DATA_W-1:0] in_read_data2,
    input  logic [DATA_W-1:0] in_extended_bits,
    input  logic [DATA_W-1:0] in_new_pc_value,
    input  logic              wb_valid,
    input  logic              wb_RegWrite,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              stall_out,
    output logic              out_valid,
    output logic              RegWrite_out,
    output logic              MemWrite_out,
    output logic              MemRead_out,
    output logic              MemToReg_out,
    output logic              zero_out,
    output logic [1:0]        load_mode_out,
    output logic [REG_W-1:0]  writebackDestination_out,
    output logic [DATA_W-1:0] aluResult_out,
    output logic [DATA_W-1:0] rt_out,
    output logic [DATA_W-1:0] pc_out
);
    localparam int unsigned ShamtW = $clog2(DATA_W);

    ex_state_e         state_q, state_d;
    ex_src_e           ex_src;
    fwd_sel_e          fwd_a, fwd_b;
    logic [31:0]       op_val;
    logic              is_mul;
    logic [DATA_W-1:0] op_a, b_raw, op_b, alu_res;
    logic [ShamtW-1:0] shamt;
    logic [REG_W-1:0]  dest;
    logic              mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;

    // EX/MEM register
    logic              valid_q, rw_q, mw_q, mr_q, mtr_q, zero_q;
    logic              valid_d, rw_d, mw_d, mr_d, mtr_d, zero_d;
    logic [1:0]        lm_q, lm_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0] res_q, res_d, rt_q, rt_d, pc_q, pc_d;

    // Instruction context captured when a multiply starts
    logic              mul_rw_q, mul_mw_q, mul_mr_q, mul_mtr_q;
    logic [1:0]        mul_lm_q;
    logic [REG_W-1:0]  mul_dest_q;
    logic [DATA_W-1:0] mul_rt_q, mul_pc_q;

    assign op_val = 32'(in_ALUOp);
    assign is_mul = (op_val == OpMul);
    assign dest   = in_RegDst ? in_rd : in_rt;

    // EX/MEM beats MEM/WB; loads in EX/MEM are not forwardable and r0 never is.
    function automatic fwd_sel_e fwd_pick(input logic [REG_W-1:0] src);
        fwd_sel_e sel;
        sel = FwdRf;
        if (src != '0) begin
            if (valid_q && rw_q && !mtr_q && (dest_q == src)) begin
                sel = FwdExMem;
            end else if (wb_valid && wb_RegWrite && (wb_dest == src)) begin
                sel = FwdMemWb;
            end
        end
        return sel;
    endfunction

    assign fwd_a = fwd_pick(in_rs);
    assign fwd_b = fwd_pick(in_rt);

    always_comb begin
        case (fwd_a)
            FwdExMem: op_a = res_q;
            FwdMemWb: op_a = wb_data;
            default:  op_a = in_read_data1;
        endcase
        case (fwd_b)
            FwdExMem: b_raw = res_q;
            FwdMemWb: b_raw = wb_data;
            default:  b_raw = in_read_data2;
        endcase
    end

    assign op_b  = in_ALUSrc ? in_extended_bits : b_raw;
    assign shamt = op_b[ShamtW-1:0];

    always_comb begin
        alu_res = '0;
        case (op_val)
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = op_a - op_b;
            OpSlt:   alu_res = DATA_W'($signed(op_a) < $signed(op_b));
            OpSltu:  alu_res = DATA_W'(op_a < op_b);
            OpSll:   alu_res = op_a << shamt;
            OpSrl:   alu_res = op_a >> shamt;
            OpSra:   alu_res = DATA_W'($signed(op_a) >>> shamt);
            OpNor:   alu_res = ~(op_a | op_b);
            OpXor:   alu_res = op_a ^ op_b;
            default: alu_res = '0;
        endcase
    end

    ex_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .hold    (mem_stall),
        .abort   (flush),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // The multiplier's busy flag tracks the MUL state exactly.
    assign stall_out = mem_stall
                     | ((state_q == StIdle) & in_valid & is_mul)
                     | (mul_busy & ~mul_done);

    always_comb begin
        state_d   = state_q;
        ex_src    = ExHold;
        mul_start = 1'b0;
        if (flush) begin
            state_d = StIdle;
            ex_src  = ExBubble;
        end else if (!mem_stall) begin
            case (state_q)
                StIdle: begin
                    if (in_valid && is_mul) begin
                        state_d   = StMul;
                        mul_start = 1'b1;
                        ex_src    = ExBubble;
                    end else if (in_valid) begin
                        ex_src = ExAlu;
                    end else begin
                        ex_src = ExBubble;
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        state_d = StIdle;
                        ex_src  = ExMul;
                    end else begin
                        ex_src = ExBubble;
                    end
                end
                default: begin
                    state_d = StIdle;
                    ex_src  = ExBubble;
                end
            endcase
        end
    end

    always_comb begin
        valid_d = 1'b0;
        rw_d    = 1'b0;
        mw_d    = 1'b0;
        mr_d    = 1'b0;
        mtr_d   = 1'b0;
        zero_d  = 1'b0;
        lm_d    = '0;
        dest_d  = '0;
        res_d   = '0;
        rt_d    = '0;
        pc_d    = '0;
        case (ex_src)
            ExHold: begin
                valid_d = valid_q;
                rw_d    = rw_q;
                mw_d    = mw_q;
                mr_d    = mr_q;
                mtr_d   = mtr_q;
                zero_d  = zero_q;
                lm_d    = lm_q;
                dest_d  = dest_q;
                res_d   = res_q;
                rt_d    = rt_q;
                pc_d    = pc_q;
            end
            ExAlu: begin
                valid_d = 1'b1;
                rw_d    = in_RegWrite;
                mw_d    = in_MemWrite;
                mr_d    = in_MemRead;
                mtr_d   = in_MemToReg;
                zero_d  = (alu_res == '0);
                lm_d    = in_load_mode;
                dest_d  = dest;
                res_d   = alu_res;
                rt_d    = b_raw;
                pc_d    = in_new_pc_value;
            end
            ExMul: begin
                valid_d = 1'b1;
                rw_d    = mul_rw_q;
                mw_d    = mul_mw_q;
                mr_d    = mul_mr_q;
                mtr_d   = mul_mtr_q;
                zero_d  = (mul_product == '0);
                lm_d    = mul_lm_q;
                dest_d  = mul_dest_q;
                res_d   = mul_product;
                rt_d    = mul_rt_q;
                pc_d    = mul_pc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            rw_q       <= 1'b0;
            mw_q       <= 1'b0;
            mr_q       <= 1'b0;
            mtr_q      <= 1'b0;
            zero_q     <= 1'b0;
            lm_q       <= '0;
            dest_q     <= '0;
            res_q      <= '0;
            rt_q       <= '0;
            pc_q       <= '0;
            mul_rw_q   <= 1'b0;
            mul_mw_q   <= 1'b0;
            mul_mr_q   <= 1'b0;
            mul_mtr_q  <= 1'b0;
            mul_lm_q   <= '0;
            mul_dest_q <= '0;
            mul_rt_q   <= '0;
            mul_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rw_q    <= rw_d;
            mw_q    <= mw_d;
            mr_q    <= mr_d;
            mtr_q   <= mtr_d;
            zero_q  <= zero_d;
            lm_q    <= lm_d;
            dest_q  <= dest_d;
            res_q   <= res_d;
            rt_q    <= rt_d;
            pc_q    <= pc_d;
            if (mul_start) begin
                mul_rw_q   <= in_RegWrite;
                mul_mw_q   <= in_MemWrite;
                mul_mr_q   <= in_MemRead;
                mul_mtr_q  <= in_MemToReg;
                mul_lm_q   <= in_load_mode;
                mul_dest_q <= dest;
                mul_rt_q   <= b_raw;
                mul_pc_q   <= in_new_pc_value;
            end
        end
    end

    assign out_valid                = valid_q;
    assign RegWrite_out             = rw_q;
    assign MemWrite_out             = mw_q;
    assign MemRead_out              = mr_q;
    assign MemToReg_out             = mtr_q;
    assign zero_out                 = zero_q;
    assign load_mode_out            = lm_q;
    assign writebackDestination_out = dest_q;
    assign aluResult_out            = res_q;
    assign rt_out                   = rt_q;
    assign pc_out                   = pc_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: directed scenarios plus randomized
// instruction streams compared cycle by cycle against a behavioural model.
// A second instance with DATA_W=8 exercises the multiplier width parameter.
module tb_ex_stage_pipe;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic        valid, regdst, regwrite, alusrc, memwrite, memread, memtoreg;
        logic [3:0]  op;
        logic [1:0]  lm;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm, pc;
    } instr_t;

    typedef struct packed {
        logic        valid, regwrite, memwrite, memread, memtoreg, zero;
        logic [1:0]  lm;
        logic [4:0]  dest;
        logic [31:0] result, rt, pc;
    } exmem_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, mem_stall;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    instr_t      cur, c8;

    logic        stall_out, out_valid, rw_out, mw_out, mr_out, mtr_out, zero_out;
    logic [1:0]  lm_out;
    logic [4:0]  dest_out;
    logic [31:0] res_out, rt_out, pc_out;

    logic        st8, v8, rw8, mw8, mr8, mtr8, z8;
    logic [1:0]  lm8;
    logic [4:0]  dst8;
    logic [7:0]  r8, rt8, pc8;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    exmem_t m_q, m_pend;
    bit     m_busy;
    int     m_left;
    logic   exp_stall_q;
    logic   last_stall;

    ex_stage_pipe #(.DATA_W(32), .REG_W(5), .OP_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(cur.valid), .in_RegDst(cur.regdst),
        .in_RegWrite(cur.regwrite), .in_ALUSrc(cur.alusrc), .in_MemWrite(cur.memwrite),
        .in_MemRead(cur.memread), .in_MemToReg(cur.memtoreg), .in_ALUOp(cur.op),
        .in_load_mode(cur.lm), .in_rs(cur.rs), .in_rt(cur.rt), .in_rd(cur.rd),
        .in_read_data1(cur.d1), .in_read_data2(cur.d2), .in_extended_bits(cur.imm),
        .in_new_pc_value(cur.pc), .wb_valid(wb_valid), .wb_RegWrite(wb_regwrite),
        .wb_dest(wb_dest), .wb_data(wb_data), .flush(flush), .mem_stall(mem_stall),
        .stall_out(stall_out), .out_valid(out_valid), .RegWrite_out(rw_out),
        .MemWrite_out(mw_out), .MemRead_out(mr_out), .MemToReg_out(mtr_out),
        .zero_out(zero_out), .load_mode_out(lm_out), .writebackDestination_out(dest_out),
        .aluResult_out(res_out), .rt_out(rt_out), .pc_out(pc_out)
    );

    ex_stage_pipe #(.DATA_W(8), .REG_W(5), .OP_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(c8.valid), .in_RegDst(c8.regdst),
        .in_RegWrite(c8.regwrite), .in_ALUSrc(c8.alusrc), .in_MemWrite(c8.memwrite),
        .in_MemRead(c8.memread), .in_MemToReg(c8.memtoreg), .in_ALUOp(c8.op),
        .in_load_mode(c8.lm), .in_rs(c8.rs), .in_rt(c8.rt), .in_rd(c8.rd),
        .in_read_data1(c8.d1[7:0]), .in_read_data2(c8.d2[7:0]),
        .in_extended_bits(c8.imm[7:0]), .in_new_pc_value(c8.pc[7:0]),
        .wb_valid(1'b0), .wb_RegWrite(1'b0), .wb_dest(5'd0), .wb_data(8'd0),
        .flush(1'b0), .mem_stall(1'b0), .stall_out(st8), .out_valid(v8),
        .RegWrite_out(rw8), .MemWrite_out(mw8), .MemRead_out(mr8), .MemToReg_out(mtr8),
        .zero_out(z8), .load_mode_out(lm8), .writebackDestination_out(dst8),
        .aluResult_out(r8), .rt_out(rt8), .pc_out(pc8)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exmem_t obs_now();
        return {out_valid, rw_out, mw_out, mr_out, mtr_out, zero_out, lm_out, dest_out,
                res_out, rt_out, pc_out};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] prod;
        case (int'(op))
            0:  return a & b;
            1:  return a | b;
            2:  return a + b;
            3:  return a - b;
            4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5:  return (a < b) ? 32'd1 : 32'd0;
            6:  return a << b[4:0];
            7:  return a >> b[4:0];
            8:  return 32'($signed(a) >>> b[4:0]);
            9:  return ~(a | b);
            10: return a ^ b;
            12: begin
                prod = 64'(a) * 64'(b);
                return prod[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        if (src == 5'd0) return rf;
        if (m_q.valid && m_q.regwrite && !m_q.memtoreg && m_q.dest == src) return m_q.result;
        if (wb_valid && wb_regwrite && wb_dest == src) return wb_data;
        return rf;
    endfunction

    // One clock: check stall/outputs mid-cycle, advance the model over the edge.
    task automatic step();
        exmem_t      nxt, tmp;
        logic [31:0] a, braw, b, res;
        logic        exp_stall;
        @(negedge clk);
        exp_stall = mem_stall | (!m_busy && cur.valid && cur.op == 4'd12)
                  | (m_busy && m_left != 1);
        check("stall_out", stall_out, exp_stall);
        check("exmem", obs_now(), m_q);
        exp_stall_q = exp_stall;
        last_stall  = stall_out;
        nxt = m_q;
        if (flush) begin
            nxt    = '0;
            m_busy = 1'b0;
        end else if (!mem_stall) begin
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    nxt    = m_pend;
                    m_busy = 1'b0;
                end else begin
                    nxt = '0;
                end
            end else if (cur.valid) begin
                a    = fwd(cur.rs, cur.d1);
                braw = fwd(cur.rt, cur.d2);
                b    = cur.alusrc ? cur.imm : braw;
                res  = ref_alu(cur.op, a, b);
                tmp  = {1'b1, cur.regwrite, cur.memwrite, cur.memread, cur.memtoreg,
                        res == 32'd0, cur.lm, cur.regdst ? cur.rd : cur.rt, res, braw, cur.pc};
                if (cur.op == 4'd12) begin
                    m_pend = tmp;
                    m_busy = 1'b1;
                    m_left = W;
                    nxt    = '0;
                end else begin
                    nxt = tmp;
                end
            end else begin
                nxt = '0;
            end
        end
        @(posedge clk);
        m_q = nxt;
        #1;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom % 4)
            0:       return $urandom;
            1:       return $urandom % 8;
            2:       return 32'hFFFF_FFFF - ($urandom % 4);
            default: return 32'h8000_0000 ^ ($urandom % 4);
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid    = ($urandom % 4) != 0;
        i.regdst   = 1'($urandom);
        i.regwrite = 1'($urandom);
        i.alusrc   = ($urandom % 4) == 0;
        i.memwrite = 1'($urandom);
        i.memread  = 1'($urandom);
        i.memtoreg = ($urandom % 4) == 0;
        i.op       = 4'($urandom);
        if (i.op == 4'd12 && ($urandom % 4) != 0) i.op = 4'd2;
        i.lm       = 2'($urandom);
        i.rs       = 5'($urandom % 4);
        i.rt       = 5'($urandom % 4);
        i.rd       = 5'($urandom % 4);
        i.d1       = rnd_word();
        i.d2       = rnd_word();
        i.imm      = rnd_word();
        i.pc       = $urandom;
        return i;
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] d1,
                                  input logic [31:0] d2);
        instr_t i;
        i = '0;
        i.valid    = 1'b1;
        i.regdst   = 1'b1;
        i.regwrite = 1'b1;
        i.op       = op;
        i.rs       = rs;
        i.rt       = rt;
        i.rd       = rd;
        i.d1       = d1;
        i.d2       = d2;
        i.pc       = 32'h0000_1000 + 32'(rd);
        return i;
    endfunction

    task automatic mul8(input logic [7:0] a, input logic [7:0] b);
        int   cnt;
        logic fin;
        logic [15:0] prod;
        c8     = mk(4'd12, 5'd1, 5'd2, 5'd7, 32'(a), 32'(b));
        c8.pc  = 32'h5A;
        prod   = 16'(a) * 16'(b);
        cnt    = 0;
        fin    = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk);
            if (st8) begin
                cnt++;
                if (k > 0) check("mul8_bubble", {v8, rw8, r8}, '0);
            end else begin
                fin = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        c8.valid = 1'b0;
        check("mul8_done", fin, 1'b1);
        check("mul8_stall_cycles", cnt, 8);
        check("mul8_result", r8, prod[7:0]);
        check("mul8_ctl", {v8, rw8, mw8, mr8, mtr8, z8, lm8, dst8, rt8, pc8},
              {6'b110000 | 6'(prod[7:0] == 8'd0), 2'd0, 5'd7, b, 8'h5A});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
        wb_valid = 1'b0; wb_regwrite = 1'b0; wb_dest = '0; wb_data = '0;
        cur = '0; c8 = '0;
        m_q = '0; m_pend = '0; m_busy = 1'b0; m_left = 0;
        exp_stall_q = 1'b0; last_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", obs_now(), '0);
        check("rst_stall", stall_out, 1'b0);
        check("rst_outputs8", {st8, v8, rw8, mw8, mr8, mtr8, z8, lm8, dst8, r8, rt8, pc8}, '0);
        rst = 1'b0;
        #1;
        check("rst_release_stall", stall_out, 1'b0);

        // DATA_W=8 multiplier while the main instance idles on bubbles
        mul8(8'd15, 8'd17);
        for (int k = 0; k < 3; k++) mul8(8'($urandom), 8'($urandom));

        // Forwarding: EX/MEM wins over MEM/WB
        cur = mk(4'd2, 5'd1, 5'd2, 5'd3, 32'd7, 32'd7);
        step();
        check("add_result", res_out, 32'd14);
        cur = mk(4'd3, 5'd3, 5'd5, 5'd4, 32'd0, 32'd4);
        wb_valid = 1'b1; wb_regwrite = 1'b1; wb_dest = 5'd3; wb_data = 32'd99;
        step();
        check("sub_fwd_result", res_out, 32'd10);
        check("sub_fwd_zero", zero_out, 1'b0);
        wb_valid = 1'b0; wb_regwrite = 1'b0;

        // MUL 7*8: 32 stall cycles then the result
        cur = mk(4'd12, 5'd10, 5'd11, 5'd12, 32'd7, 32'd8);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (last_stall) cnt++;
            else break;
        end
        check("mul_stall_cycles", cnt, 32);
        check("mul_result", res_out, 32'd56);
        check("mul_valid", out_valid, 1'b1);

        // Flush at multiplier cycle 5
        cur = mk(4'd12, 5'd10, 5'd11, 5'd13, 32'd9, 32'd9);
        repeat (5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        cur = mk(4'd2, 5'd14, 5'd15, 5'd16, 32'd1, 32'd2);
        #1;
        check("flush_stall", stall_out, 1'b0);
        check("flush_valid", out_valid, 1'b0);
        step();
        check("post_flush_add", {out_valid, res_out}, {1'b1, 32'd3});

        // Load held in EX/MEM across a 3-cycle mem_stall
        cur = mk(4'd2, 5'd17, 5'd0, 5'd0, 32'd100, 32'd0);
        cur.regdst = 1'b0; cur.rt = 5'd18; cur.alusrc = 1'b1; cur.imm = 32'd32;
        cur.memread = 1'b1; cur.memtoreg = 1'b1; cur.lm = 2'd2;
        step();
        check("lw_result", {res_out, mr_out, lm_out}, {32'd132, 1'b1, 2'd2});
        cur = mk(4'd10, 5'd19, 5'd20, 5'd21, 32'h0F, 32'hF0);
        mem_stall = 1'b1;
        repeat (3) step();
        check("lw_hold", {out_valid, res_out, mr_out, lm_out, dest_out},
              {1'b1, 32'd132, 1'b1, 2'd2, 5'd18});
        check("lw_stall", stall_out, 1'b1);
        mem_stall = 1'b0;
        step();
        check("after_release", {res_out, dest_out}, {32'hFF, 5'd21});

        // Wrap-around and r0 never forwarded
        cur = mk(4'd2, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        check("wrap_result", {res_out, zero_out}, {32'd0, 1'b1});
        cur = mk(4'd2, 5'd0, 5'd0, 5'd8, 32'd5, 32'd6);
        wb_valid = 1'b1; wb_regwrite = 1'b1; wb_dest = 5'd0; wb_data = 32'd77;
        step();
        check("r0_no_fwd", res_out, 32'd11);

        // Randomized stream; upstream holds ID/EX while stalled
        cur = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!exp_stall_q || flush) cur = rand_instr();
            wb_valid    = 1'($urandom);
            wb_regwrite = 1'($urandom);
            wb_dest     = 5'($urandom % 4);
            wb_data     = rnd_word();
            flush       = ($urandom % 40) == 0;
            mem_stall   = ($urandom % 8) == 0;
            step();
        end
        flush = 1'b0; mem_stall = 1'b0; cur = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
